// File: rtl/polar_enc_rr_scheduler.sv
// polar_enc_rr_scheduler: round-robin sharing of one polar/CRC16 encoder core with timeout recovery
module polar_enc_rr_scheduler #(
  parameter int N_REQ   = 4,
  parameter int ID_W    = 2,
  parameter int TIMEOUT = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_REQ-1:0]      req_valid_i,
  input  logic [24*N_REQ-1:0]   req_data_i,
  output logic [N_REQ-1:0]      req_ready_o,
  output logic                  enc_start_o,
  output logic [23:0]           enc_data_o,
  input  logic                  enc_done_i,
  input  logic [63:0]           enc_codeword_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [ID_W-1:0]       rsp_id_o,
  output logic [63:0]           rsp_codeword_o,
  output logic                  rsp_err_o,
  output logic                  busy_o,
  output logic [15:0]           jobs_ok_o
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  state_t state_q, state_d;
  logic [ID_W-1:0] ptr_q, ptr_d, id_q, id_d, off, gnt;
  logic [ID_W:0] sum;
  logic [7:0] timer_q, timer_d;
  logic [15:0] jobs_ok_q, jobs_ok_d;
  logic [23:0] data_q, data_d;
  logic [63:0] cw_q, cw_d;
  logic err_q, err_d, found;
  logic [N_REQ-1:0] rot;
  assign rot = N_REQ'({req_valid_i, req_valid_i} >> ptr_q);
  always_comb begin
    found = 1'b0;
    off = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (rot[k]) begin
        found = 1'b1;
        off = ID_W'(k);
      end
    end
  end
  assign sum = {1'b0, ptr_q} + {1'b0, off};
  assign gnt = sum >= (ID_W+1)'(N_REQ) ? ID_W'(sum - (ID_W+1)'(N_REQ)) : sum[ID_W-1:0];
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    id_d      = id_q;
    timer_d   = timer_q;
    jobs_ok_d = jobs_ok_q;
    data_d    = data_q;
    cw_d      = cw_q;
    err_d     = err_q;
    unique case (state_q)
      IDLE: if (found) begin
        id_d    = gnt;
        data_d  = req_data_i[24*gnt +: 24];
        state_d = ISSUE;
      end
      ISSUE: begin
        timer_d = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (enc_done_i || timer_q == 8'(TIMEOUT - 1)) state_d = RESP;
        cw_d    = enc_done_i ? enc_codeword_i : (timer_q == 8'(TIMEOUT - 1) ? 64'd0 : cw_q);
        err_d   = enc_done_i ? 1'b0 : (timer_q == 8'(TIMEOUT - 1) ? 1'b1 : err_q);
        timer_d = timer_q + 8'd1;
      end
      RESP: if (rsp_ready_i) begin
        ptr_d     = id_q == ID_W'(N_REQ - 1) ? '0 : id_q + ID_W'(1);
        jobs_ok_d = jobs_ok_q + {15'd0, ~err_q};
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      id_q      <= '0;
      timer_q   <= '0;
      jobs_ok_q <= '0;
      data_q    <= '0;
      cw_q      <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      id_q      <= id_d;
      timer_q   <= timer_d;
      jobs_ok_q <= jobs_ok_d;
      data_q    <= data_d;
      cw_q      <= cw_d;
      err_q     <= err_d;
    end
  end
  assign req_ready_o    = (state_q == IDLE && found) ? N_REQ'(1) << gnt : '0;
  assign enc_start_o    = state_q == ISSUE;
  assign enc_data_o     = data_q;
  assign rsp_valid_o    = state_q == RESP;
  assign rsp_id_o       = id_q;
  assign rsp_codeword_o = cw_q;
  assign rsp_err_o      = err_q;
  assign busy_o         = state_q != IDLE;
  assign jobs_ok_o      = jobs_ok_q;
endmodule

// File: tb/tb_polar_enc_rr_scheduler.sv
// tb_polar_enc_rr_scheduler: directed and random checks of the encoder scheduler against a job-level model
module tb_polar_enc_rr_scheduler;
  localparam int N = 4, IW = 2, TO = 15;
  logic clk = 1'b0, rst = 1'b1;
  logic [N-1:0] req_valid = '0, req_ready;
  logic [24*N-1:0] req_data = '0;
  logic enc_start, enc_done, rsp_valid, rsp_ready = 1'b1, rsp_err, busy;
  logic [23:0] enc_data;
  logic [63:0] enc_codeword = '0, rsp_codeword, core_cw = '0;
  logic [IW-1:0] rsp_id;
  logic [15:0] jobs_ok;
  logic hang = 1'b0, inj = 1'b0;
  logic [2:0] p = '0;
  int n_chk = 0, n_pass = 0;
  bit pend [N];
  logic [23:0] pdat [N];
  bit m_busy, m_err;
  logic [IW-1:0] m_id, m_ptr;
  logic [23:0] m_data;
  logic [63:0] m_cw;
  logic [15:0] m_cnt;
  int m_acc, m_rs, c;
  int grants [$];

  polar_enc_rr_scheduler #(.N_REQ(N), .ID_W(IW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .req_valid_i(req_valid), .req_data_i(req_data), .req_ready_o(req_ready),
    .enc_start_o(enc_start), .enc_data_o(enc_data), .enc_done_i(enc_done), .enc_codeword_i(enc_codeword),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_id_o(rsp_id), .rsp_codeword_o(rsp_codeword),
    .rsp_err_o(rsp_err), .busy_o(busy), .jobs_ok_o(jobs_ok));

  always #5 clk = ~clk;

  function automatic logic [63:0] gold(input logic [23:0] d);
    logic [15:0] crc = 16'hFFFF;
    for (int i = 23; i >= 0; i--) crc = {crc[14:0], 1'b0} ^ ((crc[15] ^ d[i]) ? 16'h1021 : 16'h0000);
    return {d ^ 24'h5A5A5A, crc, d};
  endfunction

  // encoder core stand-in: done three edges after start, garbage codeword otherwise
  always @(posedge clk) begin
    if (rst) p <= '0;
    else p <= {p[1:0], enc_start & ~hang};
    if (enc_start) core_cw <= gold(enc_data);
    enc_codeword <= p[1] ? core_cw : {$urandom, $urandom};
  end
  assign enc_done = p[2] | inj;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      req_valid[i] = pend[i];
      req_data[24*i +: 24] = pdat[i];
    end
  endtask

  function automatic int pick();
    for (int k = 0; k < N; k++) if (pend[(int'(m_ptr) + k) % N]) return (int'(m_ptr) + k) % N;
    return -1;
  endfunction

  function automatic bit anyp();
    for (int i = 0; i < N; i++) if (pend[i]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic cycle();
    int g;
    bit es, ev;
    logic [N-1:0] er;
    @(negedge clk);
    g = m_busy ? -1 : pick();
    er = (g < 0) ? '0 : N'(1) << g;
    chk("req_ready", 64'(req_ready), 64'(er));
    es = m_busy && c == m_acc + 1;
    chk("enc_start", 64'(enc_start), 64'(es));
    if (es) chk("enc_data", 64'(enc_data), 64'(m_data));
    ev = m_busy && c >= m_rs;
    chk("rsp_valid", 64'(rsp_valid), 64'(ev));
    if (ev) begin
      chk("rsp_id", 64'(rsp_id), 64'(m_id));
      chk("rsp_codeword", rsp_codeword, m_cw);
      chk("rsp_err", 64'(rsp_err), 64'(m_err));
    end
    chk("busy", 64'(busy), 64'(m_busy));
    chk("jobs_ok", 64'(jobs_ok), 64'(m_cnt));
    if (ev && rsp_ready) begin
      m_ptr = IW'((int'(m_id) + 1) % N);
      if (!m_err) m_cnt++;
      m_busy = 1'b0;
    end
    if (g >= 0) begin
      m_busy = 1'b1;
      m_id = IW'(g);
      m_data = pdat[g];
      m_err = hang;
      m_cw = hang ? 64'd0 : gold(pdat[g]);
      m_acc = c;
      m_rs = c + (hang ? 2 + TO : 5);
      pend[g] = 1'b0;
      grants.push_back(g);
    end
    c++;
    @(posedge clk);
    #1;
    drive();
  endtask

  task automatic run_until_idle(input int maxc);
    for (int i = 0; i < maxc && (m_busy || anyp()); i++) cycle();
    chk("drain_bound", 64'(m_busy || anyp()), 64'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    for (int i = 0; i < N; i++) pend[i] = 1'b0;
    drive();
    @(posedge clk);
    #1;
    rst = 1'b0;
    m_busy = 1'b0;
    m_ptr = '0;
    m_cnt = '0;
    @(negedge clk);
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_enc_start", 64'(enc_start), 64'd0);
    chk("rst_enc_data", 64'(enc_data), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_rsp_id", 64'(rsp_id), 64'd0);
    chk("rst_rsp_codeword", rsp_codeword, 64'd0);
    chk("rst_rsp_err", 64'(rsp_err), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_jobs_ok", 64'(jobs_ok), 64'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < N; i++) pdat[i] = '0;
    do_reset();
    pend[2] = 1'b1;
    pdat[2] = 24'hABCDEF;
    drive();
    run_until_idle(20);
    chk("single_grant", 64'(grants[0]), 64'd2);
    chk("single_jobs_ok", 64'(jobs_ok), 64'd1);
    do_reset();
    grants.delete();
    for (int i = 0; i < N; i++) begin
      pend[i] = 1'b1;
      pdat[i] = 24'($urandom);
    end
    drive();
    for (int i = 0; i < 100 && grants.size() < 8; i++) begin
      cycle();
      for (int k = 0; k < N; k++) if (!pend[k]) begin
        pend[k] = 1'b1;
        pdat[k] = 24'($urandom);
      end
      drive();
    end
    for (int i = 0; i < N; i++) pend[i] = 1'b0;
    drive();
    run_until_idle(20);
    chk("fair_count", 64'(grants.size() >= 8), 64'd1);
    for (int i = 0; i < 8 && i < grants.size(); i++) chk($sformatf("fair_grant%0d", i), 64'(grants[i]), 64'(i % 4));
    pend[1] = 1'b1;
    pend[3] = 1'b1;
    pdat[1] = 24'h123456;
    pdat[3] = 24'h0F0F0F;
    rsp_ready = 1'b0;
    drive();
    for (int i = 0; i < 40 && !(m_busy && c > m_rs + 10); i++) cycle();
    rsp_ready = 1'b1;
    run_until_idle(30);
    hang = 1'b1;
    pend[0] = 1'b1;
    pdat[0] = 24'h777777;
    drive();
    run_until_idle(40);
    hang = 1'b0;
    pend[2] = 1'b1;
    pdat[2] = 24'h2468AC;
    drive();
    run_until_idle(20);
    pend[2] = 1'b1;
    pdat[2] = 24'h13579B;
    drive();
    for (int i = 0; i < 10 && !(m_busy && c == m_acc + 3); i++) cycle();
    do_reset();
    inj = 1'b1;
    cycle();
    inj = 1'b0;
    cycle();
    grants.delete();
    pend[1] = 1'b1;
    pend[3] = 1'b1;
    drive();
    run_until_idle(30);
    chk("post_rst_grant", 64'(grants[0]), 64'd1);
    force dut.jobs_ok_q = 16'hFFFF;
    @(posedge clk);
    #1;
    release dut.jobs_ok_q;
    m_cnt = 16'hFFFF;
    pend[0] = 1'b1;
    pdat[0] = 24'h0000AA;
    drive();
    run_until_idle(20);
    chk("wrap_jobs_ok", 64'(jobs_ok), 64'd0);
    for (int i = 0; i < 600; i++) begin
      for (int k = 0; k < N; k++) if (!pend[k] && $urandom_range(2) == 0) begin
        pend[k] = 1'b1;
        pdat[k] = 24'($urandom);
      end
      rsp_ready = $urandom_range(2) != 0;
      if (!m_busy) hang = $urandom_range(7) == 0;
      drive();
      cycle();
    end
    for (int i = 0; i < N; i++) pend[i] = 1'b0;
    rsp_ready = 1'b1;
    drive();
    run_until_idle(60);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
